hwag_spi_tx_data_frame: RTL and testbench

HWAG_SPI_TX_DATA_FRAME -- requirements
Module: hwag_spi_tx_data_frame

---
 rtl/hwag_spi_tx_data_frame_pkg.sv | 37 +++
 rtl/hwag_spi_tx_data_frame_crc8_byte.sv | 21 ++
 rtl/hwag_spi_tx_data_frame.sv | 137 +++++++++++++
 tb/tb_hwag_spi_tx_data_frame.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_spi_tx_data_frame_pkg.sv
// Shared types and constants for the SPI transmit response framer.
// The optional CRC byte is built only when HWAG_SPI_TX_CRC_EN is defined.
package hwag_spi_tx_data_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    PAD  = 2'd2
  } state_t;

  localparam int         HWAG_SPI_FRAME_BYTES = 7;
  localparam logic [2:0] LAST_IDX             = 3'(HWAG_SPI_FRAME_BYTES - 1);
  localparam logic [7:0] CRC8_POLY            = 8'h07;

  localparam logic [3:0] STATUS_TAG          = 4'hA;
  localparam int         STATUS_OVERRUN_BIT  = 3;
  localparam int         STATUS_CRC_ERR_BIT  = 2;
  localparam int         STATUS_READ_OK_BIT  = 1;

  typedef struct packed {
    logic        overrun;
    logic        crc_err;
    logic        read_ok;
    logic [7:0]  addr;
    logic [31:0] data;
  } resp_t;

  function automatic logic [7:0] status_byte(input resp_t r);
    logic [7:0] s;
    s                     = {STATUS_TAG, 4'h0};
    s[STATUS_OVERRUN_BIT] = r.overrun;
    s[STATUS_CRC_ERR_BIT] = r.crc_err;
    s[STATUS_READ_OK_BIT] = r.read_ok;
    return s;
  endfunction

endpackage

// File: rtl/hwag_spi_tx_data_frame_crc8_byte.sv
// One byte step of CRC8 (poly 0x07, MSB first, no reflection); purely combinational.
module hwag_spi_tx_crc8_byte
  import hwag_spi_tx_data_frame_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  // NOTE: blocking assignments are correct here: each loop pass must see the previous pass's value.
  always_comb begin
    c = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/hwag_spi_tx_data_frame.sv
// Builds a 7-byte SPI response at frame end and shifts it out during the next frame.
// Define HWAG_SPI_TX_CRC_EN to make byte 6 a CRC8 of bytes 0..5 (otherwise 8'h00).
module hwag_spi_tx_data_frame
  import hwag_spi_tx_data_frame_pkg::*;
#(
  parameter logic [7:0] READ_CMD  = 8'h02,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_ss,
  input  logic        spi_tx,
  input  logic [7:0]  rx_cmd,
  input  logic [7:0]  rx_addr,
  input  logic        rx_crc_ok,
  input  logic        rx_frame_end,
  output logic [7:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_byte,
  output logic        frame_busy,
  output logic        resp_valid
);

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic       ss_q;
  logic       aborted;
  resp_t      resp_q;
  logic [7:0] payload [HWAG_SPI_FRAME_BYTES-1];
  logic [7:0] crc_byte;

  logic ss_fall, abort_now, tx_advance, tx_last, rx_read_ok;

  assign rd_addr    = rx_addr;
  assign ss_fall    = ss_q & ~spi_ss;
  assign abort_now  = (state == SEND) & spi_ss;
  assign tx_advance = (state == SEND) & ~spi_ss & spi_tx;
  assign tx_last    = tx_advance & (idx == LAST_IDX);
  assign rx_read_ok = rx_crc_ok & (rx_cmd == READ_CMD);

  // State register plus the datapath registers that move with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ss_q  <= 1'b1;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      ss_q  <= spi_ss;
      if (state != SEND)
        idx <= '0;
      else if (tx_advance && idx != LAST_IDX)
        idx <= idx + 3'd1;
    end
  end

  // NOTE: the response buffer is small flops, not RAM, so it takes the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q     <= '0;
      aborted    <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      if (rx_frame_end) begin
        // An abort seen in this very cycle still counts against the previous response.
        resp_q.overrun <= aborted | abort_now;
        resp_q.crc_err <= ~rx_crc_ok;
        resp_q.read_ok <= rx_read_ok;
        resp_q.addr    <= rx_addr;
        resp_q.data    <= rx_read_ok ? rd_data : 32'h0;
        aborted        <= 1'b0;
        resp_valid     <= 1'b1;
      end else begin
        if (abort_now) aborted    <= 1'b1;
        if (tx_last)   resp_valid <= 1'b0;
      end
    end
  end

  // NOTE: every comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ss_fall) state_nxt = SEND;
      SEND:    if (spi_ss) state_nxt = IDLE;
               else if (tx_last) state_nxt = PAD;
      PAD:     if (spi_ss) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    payload[0] = status_byte(resp_q);
    payload[1] = resp_q.addr;
    payload[2] = resp_q.data[31:24];
    payload[3] = resp_q.data[23:16];
    payload[4] = resp_q.data[15:8];
    payload[5] = resp_q.data[7:0];
  end

`ifdef HWAG_SPI_TX_CRC_EN
  logic [7:0] crc_chain [HWAG_SPI_FRAME_BYTES];

  assign crc_chain[0] = 8'h00;

  for (genvar g = 0; g < HWAG_SPI_FRAME_BYTES - 1; g++) begin : g_crc
    hwag_spi_tx_crc8_byte u_step (
      .crc_in  (crc_chain[g]),
      .byte_in (payload[g]),
      .crc_out (crc_chain[g+1])
    );
  end

  // The buffer is static between latches, so this equals the CRC taken at latch time.
  assign crc_byte = crc_chain[HWAG_SPI_FRAME_BYTES-1];
`else
  assign crc_byte = 8'h00;
`endif

  always_comb begin
    tx_byte    = IDLE_BYTE;
    frame_busy = 1'b0;
    if (state == SEND) begin
      frame_busy = 1'b1;
      case (idx)
        3'd0:    tx_byte = payload[0];
        3'd1:    tx_byte = payload[1];
        3'd2:    tx_byte = payload[2];
        3'd3:    tx_byte = payload[3];
        3'd4:    tx_byte = payload[4];
        3'd5:    tx_byte = payload[5];
        default: tx_byte = crc_byte;
      endcase
    end
  end

endmodule

// File: tb/tb_hwag_spi_tx_data_frame.sv
// Self-checking bench: directed scenarios plus randomized frames against a byte-level model.
module tb_hwag_spi_tx_data_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_ss;
  logic        spi_tx;
  logic [7:0]  rx_cmd;
  logic [7:0]  rx_addr;
  logic        rx_crc_ok;
  logic        rx_frame_end;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_byte;
  logic        frame_busy;
  logic        resp_valid;

  logic [7:0]  t_crc_in, t_byte, t_crc_out;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the bytes of the pending response and the frame position.
  logic [7:0] exp_b [7];
  bit         m_aborted;
  bit         m_rv;
  int         m_pos;   // -1 when select is high; 0..6 while sending; 7 after the last byte

  always #5 clk = ~clk;

  hwag_spi_tx_data_frame dut (
    .clk          (clk),
    .rst          (rst),
    .spi_ss       (spi_ss),
    .spi_tx       (spi_tx),
    .rx_cmd       (rx_cmd),
    .rx_addr      (rx_addr),
    .rx_crc_ok    (rx_crc_ok),
    .rx_frame_end (rx_frame_end),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .tx_byte      (tx_byte),
    .frame_busy   (frame_busy),
    .resp_valid   (resp_valid)
  );

  hwag_spi_tx_crc8_byte u_crc_unit (
    .crc_in  (t_crc_in),
    .byte_in (t_byte),
    .crc_out (t_crc_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // CRC8 as polynomial long division of message * x^8 by x^8+x^2+x+1.
  function automatic logic [7:0] model_crc(input logic [7:0] b0, b1, b2, b3, b4, b5);
    logic [55:0] m;
    m = {b0, b1, b2, b3, b4, b5, 8'h00};
    for (int bit_i = 55; bit_i >= 8; bit_i--)
      if (m[bit_i]) m[bit_i -: 9] = m[bit_i -: 9] ^ 9'h107;
    return m[7:0];
  endfunction

  function automatic logic [7:0] exp_tx();
    if (m_pos >= 0 && m_pos <= 6) return exp_b[m_pos];
    return 8'hFF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_fill(input logic [7:0] status, input logic [7:0] addr, input logic [31:0] data);
    exp_b[0] = status;
    exp_b[1] = addr;
    exp_b[2] = data[31:24];
    exp_b[3] = data[23:16];
    exp_b[4] = data[15:8];
    exp_b[5] = data[7:0];
`ifdef HWAG_SPI_TX_CRC_EN
    exp_b[6] = model_crc(exp_b[0], exp_b[1], exp_b[2], exp_b[3], exp_b[4], exp_b[5]);
`else
    exp_b[6] = 8'h00;
`endif
  endtask

  task automatic model_latch(input logic [7:0] cmd, addr, input bit ok, input logic [31:0] data);
    bit         rd_ok;
    logic [7:0] st;
    rd_ok = ok && (cmd == 8'h02);
    st    = 8'hA0 | (m_aborted ? 8'h08 : 8'h00) | (ok ? 8'h00 : 8'h04) | (rd_ok ? 8'h02 : 8'h00);
    model_fill(st, addr, rd_ok ? data : 32'h0);
    m_aborted = 0;
    m_rv      = 1;
  endtask

  task automatic model_reset();
    model_fill(8'hA0, 8'h00, 32'h0);
    m_aborted = 0;
    m_rv      = 0;
    m_pos     = -1;
  endtask

  task automatic drive_rx(input logic [7:0] cmd, addr, input bit ok, input logic [31:0] data);
    rx_cmd    = cmd;
    rx_addr   = addr;
    rx_crc_ok = ok;
    rd_data   = data;
  endtask

  task automatic frame_end(input logic [7:0] cmd, addr, input bit ok, input logic [31:0] data);
    drive_rx(cmd, addr, ok, data);
    #1;
    check("rd_addr", rd_addr, addr);
    rx_frame_end = 1'b1;
    step();
    rx_frame_end = 1'b0;
    model_latch(cmd, addr, ok, data);
    check("resp_valid_set", resp_valid, 1'b1);
  endtask

  task automatic start_frame();
    spi_ss = 1'b0;
    step();
    m_pos = 0;
    check("busy_start", frame_busy, 1'b1);
    check("byte0", tx_byte, exp_tx());
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        step();
        check("hold_byte", tx_byte, exp_tx());
      end
      spi_tx = 1'b1;
      step();
      spi_tx = 1'b0;
      if (m_pos == 6) m_rv = 0;
      if (m_pos <= 6) m_pos++;
      check("tx_byte", tx_byte, exp_tx());
      check("busy", frame_busy, (m_pos <= 6) ? 1'b1 : 1'b0);
      check("resp_valid", resp_valid, m_rv);
    end
  endtask

  task automatic end_frame();
    spi_ss = 1'b1;
    step();
    if (m_pos <= 6) m_aborted = 1;
    m_pos = -1;
    check("idle_byte", tx_byte, 8'hFF);
    check("busy_end", frame_busy, 1'b0);
    step();
  endtask

  initial begin
    logic [7:0] c;
    string      s;

    rst = 1'b1; spi_ss = 1'b1; spi_tx = 1'b0; rx_frame_end = 1'b0;
    drive_rx(8'h00, 8'h00, 1'b0, 32'h0);
    model_reset();
    repeat (2) step();
    check("rst_tx_byte", tx_byte, 8'hFF);
    check("rst_busy", frame_busy, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    rst = 1'b0;
    step();

    // Read response, then bad-CRC response.
    frame_end(8'h02, 8'h01, 1'b1, 32'h0012_3456);
    start_frame();
    check("read_status", tx_byte, 8'hA2);
    pulses(7);
    end_frame();
    frame_end(8'h02, 8'h01, 1'b0, 32'hDEAD_BEEF);
    start_frame();
    check("badcrc_status", tx_byte, 8'hA4);
    pulses(7);
    end_frame();

    // Abort after three bytes, then a read must report overrun.
    frame_end(8'h02, 8'h10, 1'b1, 32'h0A0B_0C0D);
    start_frame();
    pulses(3);
    end_frame();
    frame_end(8'h02, 8'h11, 1'b1, 32'h1122_3344);
    start_frame();
    check("abort_status", tx_byte, 8'hAA);
    pulses(7);
    end_frame();

    // Nine pulses in one frame: bytes 7 and 8 stay idle, no wrap.
    frame_end(8'h05, 8'h22, 1'b1, 32'hFFFF_FFFF);
    start_frame();
    pulses(9);
    end_frame();

    // Frame end coincident with select fall: the new response goes out.
    drive_rx(8'h02, 8'h33, 1'b1, 32'hCAFE_F00D);
    rx_frame_end = 1'b1;
    spi_ss       = 1'b0;
    step();
    rx_frame_end = 1'b0;
    model_latch(8'h02, 8'h33, 1'b1, 32'hCAFE_F00D);
    m_pos = 0;
    check("same_cycle_status", tx_byte, 8'hA2);
    pulses(7);
    end_frame();

    // Reset mid-SEND.
    frame_end(8'h02, 8'h44, 1'b1, 32'h5566_7788);
    start_frame();
    pulses(2);
    rst    = 1'b1;
    spi_ss = 1'b1;
    #1;
    check("rst_mid_tx_byte", tx_byte, 8'hFF);
    check("rst_mid_busy", frame_busy, 1'b0);
    check("rst_mid_resp_valid", resp_valid, 1'b0);
    step();
    rst = 1'b0;
    model_reset();
    step();
    start_frame();
    check("post_rst_status", tx_byte, 8'hA0);
    pulses(7);
    end_frame();

    // Randomized frames.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) != 0)
        frame_end(($urandom_range(0, 1) != 0) ? 8'h02 : 8'($urandom),
                  8'($urandom), 1'($urandom_range(0, 3) != 0), $urandom);
      start_frame();
      pulses($urandom_range(0, 9));
      end_frame();
    end

    // CRC step unit on the standard check string.
    s = "123456789";
    c = 8'h00;
    for (int i = 0; i < s.len(); i++) begin
      t_crc_in = c;
      t_byte   = s[i];
      #1;
      c = t_crc_out;
    end
    check("crc_check_string", c, 8'hF4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
